sub_div_4_bit: RTL and testbench
================================

SUB_DIV_4_BIT -- requirements
Module: sub_div_4_bit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 a  input  4  unsigned operand A (minuend or dividend).
REQ-005 b  input  4  unsigned operand B (subtrahend or divisor).
REQ-006 operation  input  1  0 = subtract (A-B), 1 = divide (A/B).
REQ-007 start  input  1  request pulse; sampled only when busy=0.
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking that Result has been updated.
REQ-010 Result  output  8  operation result; held stable until the next done.
REQ-011 div_by_zero  output  1  present only with SUB_DIV_4_BIT_DIVZERO_EN; see Configuration.

Function
REQ-012 The FSM SHALL have states IDLE, SUB, DIV and DONE.
REQ-013 IDLE or DONE with start=1 at a rising edge: the block latches a, b and operation; next state is SUB (operation=0) or DIV (operation=1); busy=1.
REQ-014 start while busy=1 SHALL be ignored; operand changes while busy=1 SHALL have no effect.
REQ-015 SUB: one cycle; Result = 8-bit two's-complement of A-B with A and B zero-extended; next state DONE.
REQ-016 DIV: restoring division, one quotient bit per cycle MSB first, exactly 4 cycles, 4-bit partial remainder plus a 5-bit compare.
REQ-017 DIV completion: Result[3:0] = quotient and Result[7:4] = remainder; next state DONE.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle.
REQ-019 After DONE, the FSM goes to IDLE, or back to SUB/DIV if start=1 in DONE (back-to-back, no bubble).
REQ-020 Latency from the start edge to done high: SUB 2 edges; DIV 5 edges (4 iterations plus DONE).
REQ-021 Result SHALL update only at the edge entering DONE.
REQ-022 done and busy SHALL never both be 1.

Reset
REQ-023 rst=1 SHALL force IDLE, busy=0, done=0, Result=8'h00, div_by_zero=0 and clear the latched operands, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-025 Macro SUB_DIV_4_BIT_DIVZERO_EN SHALL select divide-by-zero handling.
REQ-026 With the macro: DIV with B=0 goes directly to DONE after 1 cycle (done 2 edges after start), Result=8'h00, div_by_zero=1 for that done cycle only; the port exists.
REQ-027 Without the macro: the div_by_zero port is absent; B=0 runs the normal 4-cycle division, giving quotient 4'hF and remainder A.

Verification
REQ-028 SUB, a=3, b=5, start pulse -> done 2 edges later, Result=8'hFE, busy high for 1 cycle before done.
REQ-029 DIV, a=13, b=3 -> done 5 edges after start, Result=8'h14 (r=1, q=4); Result holds 8'h14 until the next done.
REQ-030 DIV, a=9, b=0: with the macro -> done after 2 edges, Result=8'h00, div_by_zero=1; without the macro -> done after 5 edges, Result=8'h9F.
REQ-031 DIV a=15, b=4 started, start re-pulsed with SUB a=1, b=1 mid-division -> the second start is ignored; Result=8'h33; then start in the DONE cycle with SUB a=1, b=1 -> Result=8'h00 2 edges later.
REQ-032 rst asserted 2 cycles into DIV a=7, b=2 -> busy=0 and Result=8'h00 immediately, no done; a new DIV a=7, b=2 -> Result=8'h13.

Source files
------------

// File: rtl/sub_div_4_bit.sv
// 4-bit subtract / restoring-divide unit with start/busy/done handshake.
// Optional divide-by-zero flag is enabled with SUB_DIV_4_BIT_DIVZERO_EN.
//
// state | meaning
// IDLE  | waiting for start
// SUB   | single-cycle A-B
// DIV   | restoring division, one quotient bit per cycle (4 cycles)
// DONE  | done pulse; start here launches the next operation
module sub_div_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       operation,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] Result
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
  ,
  output logic       div_by_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;

  logic [4:0] trial;
  logic [3:0] diff;
  logic       q_bit;
  logic       b_zero;

`ifdef SUB_DIV_4_BIT_DIVZERO_EN
  logic dbz_q, dbz_d;
  assign b_zero = (b_q == 4'd0);
  assign dbz_d  = (state_q == DIV) && b_zero;
`else
  assign b_zero = 1'b0;
`endif

  // a_q doubles as the dividend shift register; quotient bits shift in at the LSB
  always_comb begin
    trial = {rem_q, a_q[3]};
    diff  = trial[3:0] - b_q;
    q_bit = (trial >= {1'b0, b_q});
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          rem_d   = 4'd0;
          cnt_d   = 2'd0;
          state_d = operation ? DIV : SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        result_d = {4'd0, a_q} - {4'd0, b_q};
        state_d  = DONE;
      end
      DIV: begin
        if (b_zero) begin
          result_d = 8'h00;
          state_d  = DONE;
        end else begin
          rem_d = q_bit ? diff : trial[3:0];
          a_d   = {a_q[2:0], q_bit};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            result_d = {rem_d, a_q[2:0], q_bit};
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      rem_q    <= 4'd0;
      cnt_q    <= 2'd0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

`ifdef SUB_DIV_4_BIT_DIVZERO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`endif

  assign busy   = (state_q == SUB) || (state_q == DIV);
  assign done   = (state_q == DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_sub_div_4_bit.sv
// Bench for sub_div_4_bit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_sub_div_4_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       operation = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [7:0] Result;
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
  logic       div_by_zero;
`endif

  int errors = 0;
  int checks = 0;

  sub_div_4_bit dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .operation(operation),
    .start(start),
    .busy(busy),
    .done(done),
    .Result(Result)
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_res(input logic op, input logic [3:0] x, input logic [3:0] y);
    int d;
    if (!op) begin
      d = int'(x) - int'(y);
      return 8'(d);
    end
    if (y == 4'd0) begin
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
      return 8'h00;
`else
      return {x, 4'hF};
`endif
    end
    d = (int'(x) % int'(y)) * 16 + (int'(x) / int'(y));
    return 8'(d);
  endfunction

  function automatic int exp_lat(input logic op, input logic [3:0] y);
    if (!op) return 2;
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
    if (y == 4'd0) return 2;
`endif
    return 5;
  endfunction

  function automatic bit exp_z(input logic op, input logic [3:0] y);
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
    return op && (y == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  int         cyc = 0;
  int         m_done_cyc = 0;
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  bit         m_dbz = 1'b0;
  bit         m_pend_dbz = 1'b0;
  logic [7:0] m_res = 8'h00;
  logic [7:0] m_pend_res = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_dbz    <= 1'b0;
      m_res    <= 8'h00;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_active) begin
        if (cyc + 1 == m_done_cyc) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_res    <= m_pend_res;
          m_dbz    <= m_pend_dbz;
        end
      end else if (start) begin
        m_active   <= 1'b1;
        m_pend_res <= exp_res(operation, a, b);
        m_pend_dbz <= exp_z(operation, b);
        m_done_cyc <= cyc + exp_lat(operation, b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("Result", 32'(Result), 32'(m_res));
      chk("busy_done_excl", 32'(busy & done), 32'd0);
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input logic op, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    operation = op;
    a = x;
    b = y;
    start = 1'b1;
  endtask

  // start must already be driven; returns at posedge+1 of the done cycle
  task automatic wait_done(input int lat, input logic [7:0] exp, input string nm, input bit glitch);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (glitch && n == 2) begin
        start = 1'b1; operation = 1'b0; a = 4'd1; b = 4'd1;
      end
      if (glitch && n == 3) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no done expected done within %0d edges", nm, lat);
    end else begin
      chk({nm, "_latency"}, 32'(n), 32'(lat));
      chk({nm, "_result"}, 32'(Result), 32'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  typedef struct {
    logic       op;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] r;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 4'd0,  4'd15, 8'hF1, 2};
    vecs[1] = '{1'b1, 4'd15, 4'd1,  8'h0F, 5};
    vecs[2] = '{1'b1, 4'd2,  4'd7,  8'h20, 5};
    vecs[3] = '{1'b0, 4'd15, 4'd0,  8'h0F, 2};
    vecs[4] = '{1'b1, 4'd14, 4'd15, 8'hE0, 5};
    vecs[5] = '{1'b0, 4'd2,  4'd7,  8'hFB, 2};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_Result", 32'(Result), 32'h00);
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    go(1'b0, 4'd3, 4'd5);
    wait_done(2, 8'hFE, "sub_3_5", 1'b0);

    go(1'b1, 4'd13, 4'd3);
    wait_done(5, 8'h14, "div_13_3", 1'b0);
    @(negedge clk);
    a = 4'd15; b = 4'd15; operation = 1'b0;
    repeat (3) @(negedge clk);
    chk("div_13_3_hold", 32'(Result), 32'h14);

    go(1'b1, 4'd9, 4'd0);
`ifdef SUB_DIV_4_BIT_DIVZERO_EN
    wait_done(2, 8'h00, "div_9_0", 1'b0);
    chk("div_9_0_flag", 32'(div_by_zero), 32'd1);
    @(posedge clk);
    #1;
    chk("div_9_0_flag_clear", 32'(div_by_zero), 32'd0);
`else
    wait_done(5, 8'h9F, "div_9_0", 1'b0);
`endif

    go(1'b1, 4'd15, 4'd4);
    wait_done(5, 8'h33, "div_15_4_ignore", 1'b1);
    @(negedge clk);
    operation = 1'b0; a = 4'd1; b = 4'd1; start = 1'b1;
    wait_done(2, 8'h00, "b2b_sub_1_1", 1'b0);

    for (int i = 0; i < 6; i++) begin
      go(vecs[i].op, vecs[i].x, vecs[i].y);
      wait_done(vecs[i].lat, vecs[i].r, $sformatf("vec%0d", i), 1'b0);
    end

    go(1'b1, 4'd7, 4'd2);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_Result", 32'(Result), 32'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    go(1'b1, 4'd7, 4'd2);
    wait_done(5, 8'h13, "div_7_2_after_rst", 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
